// File: rtl/jtopl_upd_ctrl_if.sv
// CPU-side bus of the OPL write scheduler.
// Index/data write port plus the status read-back.
interface jtopl_upd_ctrl_if;
  logic       cs_n;
  logic       wr_n;
  logic       rd_n;
  logic       addr;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;

  modport master (
    output cs_n, wr_n, rd_n, addr, cpu_din,
    input  cpu_dout
  );

  modport slave (
    input  cs_n, wr_n, rd_n, addr, cpu_din,
    output cpu_dout
  );
endinterface

// File: rtl/jtopl_upd_ctrl.sv
// OPL CPU write scheduler: decodes index/data writes and holds
// each update for a full slot round, with one pending entry.
module jtopl_upd_ctrl #(
  parameter int HOLD = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  jtopl_upd_ctrl_if.slave bus,
  output logic [7:0] reg_din,
  output logic [1:0] sel_group,
  output logic [2:0] sel_sub,
  output logic       up_mult,
  output logic       up_ksl_tl,
  output logic       up_ar_dr,
  output logic       up_sl_rr,
  output logic       up_fnum,
  output logic       up_fbcon,
  output logic [7:0] latch_fnum,
  output logic       busy
);
  localparam int CW = $clog2(HOLD);
  localparam logic [CW-1:0] LAST = CW'(HOLD - 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  typedef struct packed {
    logic [5:0] up;
    logic [1:0] grp;
    logic [2:0] sub;
    logic [7:0] dat;
  } upd_t;

  logic [0:0]    st;
  logic [CW-1:0] cnt;
  logic [7:0]    idx;
  logic          wr_q;
  logic          rd_q;
  logic          ovf;
  logic          pend_v;
  upd_t          cur;
  upd_t          pend;
  upd_t          nw;

  logic wr_act;
  logic rd_act;
  logic wr_edge;
  logic op_hit;
  logic fl_hit;
  logic fn_hit;
  logic fb_hit;
  logic dec_ok;
  logic upd;
  logic done;
  logic take_new;
  logic ovf_set;

  function automatic logic [4:0] ch_map(input logic [3:0] ch);
    case (ch)
      4'd0:    ch_map = {2'd0, 3'd0};
      4'd1:    ch_map = {2'd0, 3'd1};
      4'd2:    ch_map = {2'd0, 3'd2};
      4'd3:    ch_map = {2'd1, 3'd0};
      4'd4:    ch_map = {2'd1, 3'd1};
      4'd5:    ch_map = {2'd1, 3'd2};
      4'd6:    ch_map = {2'd2, 3'd0};
      4'd7:    ch_map = {2'd2, 3'd1};
      4'd8:    ch_map = {2'd2, 3'd2};
      default: ch_map = 5'd0;
    endcase
  endfunction

  assign wr_act  = !bus.cs_n && !bus.wr_n;
  assign rd_act  = !bus.cs_n && !bus.rd_n && !bus.addr;
  assign wr_edge = wr_act && !wr_q;

  assign op_hit = (idx[7:5] != 3'd0) && (idx[7:5] <= 3'd4);
  assign fl_hit = (idx[7:4] == 4'hA) && (idx[3:0] <= 4'd8);
  assign fn_hit = (idx[7:4] == 4'hB) && (idx[3:0] <= 4'd8);
  assign fb_hit = (idx[7:4] == 4'hC) && (idx[3:0] <= 4'd8);

  always_comb begin
    nw     = '0;
    nw.dat = bus.cpu_din;
    dec_ok = 1'b0;
    unique case (1'b1)
      op_hit: begin
        nw.up  = 6'd1 << (idx[7:5] - 3'd1);
        nw.grp = idx[4:3];
        nw.sub = idx[2:0];
        dec_ok = (idx[4:3] != 2'd3) && (idx[2:0] <= 3'd5);
      end
      fn_hit: begin
        nw.up             = 6'b010000;
        {nw.grp, nw.sub}  = ch_map(idx[3:0]);
        dec_ok            = 1'b1;
      end
      fb_hit: begin
        nw.up             = 6'b100000;
        {nw.grp, nw.sub}  = ch_map(idx[3:0]);
        dec_ok            = 1'b1;
      end
      default: ;
    endcase
  end

  assign upd  = wr_edge && bus.addr && dec_ok;
  assign done = (st == S_HOLD) && cen && (cnt == LAST);
  // A window that ends with nothing pending can hand over straight to a new write.
  assign take_new = upd && ((st == S_IDLE) || (done && !pend_v));
  assign ovf_set  = upd && !take_new && pend_v && !done;

  assign busy         = (st == S_HOLD);
  assign bus.cpu_dout = {busy, ovf, 6'b0};
  assign reg_din      = cur.dat;
  assign sel_group    = cur.grp;
  assign sel_sub      = cur.sub;
  assign {up_fbcon, up_fnum, up_sl_rr,
          up_ar_dr, up_ksl_tl, up_mult} = cur.up;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_IDLE;
      cnt        <= '0;
      idx        <= 8'd0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      ovf        <= 1'b0;
      pend_v     <= 1'b0;
      cur        <= '0;
      pend       <= '0;
      latch_fnum <= 8'd0;
    end else begin
      wr_q <= wr_act;
      rd_q <= rd_act;
      if (wr_edge && !bus.addr)
        idx <= bus.cpu_din;
      if (wr_edge && bus.addr && fl_hit)
        latch_fnum <= bus.cpu_din;

      if (st == S_IDLE) begin
        if (upd) begin
          cur <= nw;
          cnt <= '0;
          st  <= S_HOLD;
        end
      end else if (cen) begin
        if (cnt == LAST) begin
          cnt <= '0;
          if (pend_v)
            cur <= pend;
          else if (upd)
            cur <= nw;
          else begin
            cur.up <= 6'd0;
            st     <= S_IDLE;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      if (upd && !take_new) begin
        if (!pend_v || done) begin
          pend   <= nw;
          pend_v <= 1'b1;
        end
      end else if (done && pend_v) begin
        pend_v <= 1'b0;
      end

      if (ovf_set)
        ovf <= 1'b1;
      else if (rd_q && !rd_act)
        ovf <= 1'b0;
    end
  end
endmodule

// File: doc/jtopl_upd_ctrl.md
Name: jtopl_upd_ctrl

Overview:
CPU-side write scheduler that feeds the OPL operator/channel register file.
- Decodes the two-port (index/data) CPU write protocol into sel_group/sel_sub plus one up_* strobe.
- Holds each update long enough for the time-multiplexed slot counter to pass the target slot.
- Queues one pending write while busy.
- Exposes busy and overflow status to the CPU.

Parameters:
HOLD, 18, number of cen ticks an update stays asserted; one full slot round (18 operators).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cen  in  1  clock enable, same as the register file's
cs_n  in  1  CPU chip select, active low
wr_n  in  1  CPU write strobe, active low
rd_n  in  1  CPU read strobe, active low
addr  in  1  0 = index port, 1 = data port
cpu_din  in  8  CPU write data
cpu_dout  out  8  status: bit7 busy, bit6 ovf, bits5:0 zero
reg_din  out  8  data presented to the register file
sel_group  out  2  target group
sel_sub  out  3  target subslot
up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_fnum, up_fbcon  out  1 each  update strobes, at most one high
latch_fnum  out  8  last fnum low byte written
busy  out  1  update in progress

Behaviour:
- Reset (async, rst_n=0): all strobes 0; reg_din, latch_fnum, index = 0; sel_group = 0, sel_sub = 0; busy = 0; pending empty; ovf = 0; hold counter = 0.
- Write detect:
  - wr_act = !cs_n & !wr_n, sampled every clk (not gated by cen).
  - Action occurs on the first clk where wr_act=1 and the previous sample was 0, i.e. one action per strobe regardless of pulse length.
- addr=0 write: index <= cpu_din. No other effect, accepted even while busy.
- addr=1 write, decoded against current index (idx):
  - Operator registers, idx[7:5] in 1..4 → mult / ksl_tl / ar_dr / sl_rr.
    - off = idx[4:0]; group = off[4:3]; sub = off[2:0].
    - Valid only if group ≤ 2 and sub ≤ 5. Otherwise the write is ignored (no busy, no ovf).
  - 0xA0–0xA8: latch_fnum <= cpu_din on the same clk. No strobe, no busy.
  - 0xB0–0xB8 → up_fnum; 0xC0–0xC8 → up_fbcon.
    - ch = idx[3:0]; group = ch/3; sub = ch%3.
  - Any other index, including 0xA9–0xAF, 0xB9–0xBF and 0xC9–0xCF: ignored.
- Scheduler FSM, states IDLE and HOLD:
  - IDLE + valid update: on the same clk, load reg_din, sel_group, sel_sub and the matching strobe; busy=1; counter=0; go to HOLD.
  - HOLD: counter increments on each cen. When the counter reaches HOLD-1 with cen=1:
    - strobes drop and counter clears.
    - If pending is valid, load pending into the outputs on that same clk, clear pending and stay in HOLD. busy remains 1.
    - Otherwise go to IDLE with busy=0.
  - reg_din, sel_group and sel_sub are stable for the whole HOLD window.
- Pending buffer, one entry holding {data, group, sub, strobe id}:
  - Valid update while busy and pending empty → stored.
  - Valid update while pending full → dropped, ovf <= 1 (sticky).
  - Same-clk drain and new arrival: the new write goes into the freed slot. It is not dropped.
- Status read: cpu_dout combinational = {busy, ovf, 6'b0}. A read is cs_n=0, rd_n=0, addr=0. ovf clears on the clk after the read strobe's rising edge; a set event on that same clk wins.
- cen=0: the FSM holds and the counter holds. Write decode and pending still operate.
- Reset mid-HOLD: all state returns to reset values immediately; pending is lost.

Test Plan:
- Index 0x20, data 0x41 → up_mult=1, sel_group=0, sel_sub=0, reg_din=0x41 for exactly 18 cen ticks; busy=1 during, 0 after.
- Index 0x4D, data 0x3F → up_ksl_tl, group=1, sub=5. Index 0x26, data 0x11 → no strobe, busy stays 0, ovf=0.
- Index 0xA4 data 0x98, then 0xB4 data 0x2D → latch_fnum=0x98; up_fnum with group=1, sub=1, reg_din=0x2D.
- Three data writes back-to-back while busy (0x60/0x80, 0x61/0x81, 0x62/0x82):
  - the first is active and the second is pending;
  - the third is dropped and the status reads 0xC0;
  - the second takes effect immediately after the first's window;
  - after a status read, ovf=0.
- Hold wr_n low for 10 clks on data 0xC0/0x0E → exactly one up_fbcon window. Toggle cen 1-in-4 → window spans 18 cen ticks (72 clk).
- Assert rst_n=0 mid-HOLD with pending valid → strobes, busy and ovf go to 0 asynchronously. After release, a new write is accepted normally.
